// File: rtl/mips_fetch_unit.sv
// PC / instruction-fetch stage for one manycore MIPS core.
// Drives the ROM address from the pc register, buffers the returned word in a
// one-entry IF buffer (valid/ready toward decode), handles branch redirects,
// halt-opcode detection and out-of-window / misaligned fetch faults.
module mips_fetch_unit #(
  parameter int          coreID      = 0,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          ROM_WORDS   = 32,
  parameter logic [5:0]  HALT_OPCODE = 6'd63
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        halted,
  output logic        fault,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {IDLE, RUN, HALTED, FAULT} state_t;

  localparam logic [31:0] WIN_BYTES = 32'(ROM_WORDS) * 32'd4;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx, instr_nx, pc_out_nx, fault_addr;
  logic        valid_nx, acc, load;

  // Offset from the window base; a single unsigned compare also rejects
  // addresses below RESET_PC because they wrap to huge offsets.
  function automatic logic in_win(input logic [31:0] a);
    return (a - RESET_PC) < WIN_BYTES;
  endfunction

  assign acc      = instr_valid & instr_ready;
  assign load     = (state == RUN) & (~instr_valid | instr_ready);
  assign rom_addr = pc;
  assign halted   = (state == HALTED);
  assign fault    = (state == FAULT);

  // Next-state and next buffer contents; everything holds unless a rule fires.
  always_comb begin
    state_nx   = state;
    pc_nx      = pc;
    instr_nx   = instr_out;
    pc_out_nx  = pc_out;
    valid_nx   = instr_valid;
    fault_addr = pc;
    case (state)
      IDLE: begin
        valid_nx = 1'b0;
        if (start) state_nx = RUN;
      end
      RUN: begin
        if (acc && branch_taken) begin
          // Redirect wins over anything detected on the word at the old pc.
          valid_nx = 1'b0;
          if (branch_target[1:0] != 2'b00 || !in_win(branch_target)) begin
            state_nx   = FAULT;
            fault_addr = branch_target;
          end else begin
            pc_nx = branch_target;
          end
        end else if (load && !in_win(pc)) begin
          state_nx = FAULT;
          valid_nx = 1'b0;
        end else if (load && rom_data[31:26] == HALT_OPCODE) begin
          // Halt word is swallowed; pc stays pointing at it.
          state_nx = HALTED;
          valid_nx = 1'b0;
        end else if (load) begin
          instr_nx  = rom_data;
          pc_out_nx = pc;
          valid_nx  = 1'b1;
          pc_nx     = pc + 32'd4;
        end
      end
      default: valid_nx = 1'b0;
    endcase
  end

  // State, pc, IF buffer and the saturating handshake counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr_out   <= '0;
      pc_out      <= '0;
      instr_valid <= 1'b0;
      fetch_count <= '0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      instr_out   <= instr_nx;
      pc_out      <= pc_out_nx;
      instr_valid <= valid_nx;
      if (acc && fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
    end
  end

`ifndef SYNTHESIS
  // Simulation-only notice on fault entry.
  always_ff @(posedge clk) begin
    if (!reset && state != FAULT && state_nx == FAULT)
      $display("core %0d: fetch fault at address 0x%08h", coreID, fault_addr);
  end
`endif

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Scoreboard bench for mips_fetch_unit: the driver pushes the expected outcome
// of every fetch address as it becomes known; the monitor pops on each
// accepted instruction or on halt/fault entry and compares.
module tb_mips_fetch_unit;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          ROM_WORDS = 32;
  localparam logic [5:0]  HALT_OP   = 6'd63;
  localparam int K_ITEM = 0, K_HALT = 1, K_FAULT = 2;

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [31:0] rom_addr, rom_data, instr_out, pc_out, branch_target = '0;
  logic        instr_valid, instr_ready = 1'b0, branch_taken = 1'b0;
  logic        halted, fault;
  logic [15:0] fetch_count;

  typedef struct {
    int          kind;
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] frz;   // address rom_addr must freeze at after halt/fault
  } exp_t;

  exp_t        q[$];
  logic [31:0] rom [ROM_WORDS];
  int          n_chk = 0, n_pass = 0;
  int          n_acc = 0;
  bit          mon_en = 0, seen_h = 0, seen_f = 0;

  always #5 clk = ~clk;

  mips_fetch_unit #(.coreID(3), .RESET_PC(RESET_PC), .ROM_WORDS(ROM_WORDS), .HALT_OPCODE(HALT_OP)) dut (
    .clk(clk), .reset(reset), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .instr_out(instr_out), .pc_out(pc_out), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .branch_taken(branch_taken), .branch_target(branch_target), .halted(halted), .fault(fault),
    .fetch_count(fetch_count));

  function automatic bit inwin(input logic [31:0] a);
    return (a >= RESET_PC) && (a < RESET_PC + 32'(4 * ROM_WORDS));
  endfunction

  function automatic logic [31:0] rom_at(input logic [31:0] a);
    logic [31:0] o;
    o = a - RESET_PC;
    return rom[o[6:2]];
  endfunction

  // Outside the window the ROM returns all ones (a halt opcode), so a fault
  // must take precedence over halt detection there.
  always_comb rom_data = inwin(rom_addr) ? rom_at(rom_addr) : 32'hFFFF_FFFF;

  // What fetching proceeds to after an accepted instruction (or start).
  function automatic exp_t outcome(input bit br, input logic [31:0] t, input logic [31:0] seq);
    exp_t        e;
    logic [31:0] a, w;
    a = br ? t : seq;
    e.pc = a; e.ins = '0; e.frz = a;
    w = inwin(a) ? rom_at(a) : 32'hFFFF_FFFF;
    if (br && (t[1:0] != 2'b00 || !inwin(t))) begin
      e.kind = K_FAULT; e.frz = seq;
    end else if (!inwin(a)) e.kind = K_FAULT;
    else if (w[31:26] == HALT_OP) e.kind = K_HALT;
    else begin e.kind = K_ITEM; e.ins = w; end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: samples 1 time unit after the falling edge.
  initial forever begin
    exp_t e;
    @(negedge clk); #1;
    if (mon_en) begin
      chk("fetch_count", 32'(fetch_count), 32'(n_acc));
      if (instr_valid && instr_ready) begin
        if (q.size() == 0) chk("unexpected_instr_pc", pc_out, 32'hxxxx_xxxx);
        else begin
          e = q.pop_front();
          chk("presented_kind", K_ITEM, e.kind);
          chk("pc_out", pc_out, e.pc);
          chk("instr_out", instr_out, e.ins);
        end
        if (n_acc < 65535) n_acc++;
      end
      if (halted && !seen_h) begin
        seen_h = 1;
        if (q.size() == 0) chk("unexpected_halt", 32'(halted), 0);
        else begin
          e = q.pop_front();
          chk("halt_kind", K_HALT, e.kind);
          chk("halt_rom_addr", rom_addr, e.frz);
        end
      end
      if (fault && !seen_f) begin
        seen_f = 1;
        if (q.size() == 0) chk("unexpected_fault", 32'(fault), 0);
        else begin
          e = q.pop_front();
          chk("fault_kind", K_FAULT, e.kind);
          chk("fault_rom_addr", rom_addr, e.frz);
        end
      end
      if (seen_h || seen_f) begin
        chk("valid_after_stop", 32'(instr_valid), 0);
        chk("halt_sticky", 32'(halted), 32'(seen_h));
        chk("fault_sticky", 32'(fault), 32'(seen_f));
      end
    end
  end

  task automatic fill_rom(input int halt_at);
    logic [31:0] w;
    for (int i = 0; i < ROM_WORDS; i++) begin
      w = $urandom;
      if (w[31:26] == HALT_OP) w[31:26] = 6'd0;
      rom[i] = w;
    end
    if (halt_at >= 0) rom[halt_at][31:26] = HALT_OP;
  endtask

  task automatic do_reset();
    @(negedge clk);
    mon_en = 0; reset = 1; start = 1; instr_ready = 1; branch_taken = 1;
    repeat (2) @(negedge clk);
    chk("rst_rom_addr", rom_addr, RESET_PC);
    chk("rst_instr_out", instr_out, 0);
    chk("rst_pc_out", pc_out, 0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_fetch_count", 32'(fetch_count), 0);
    reset = 0; start = 0; branch_taken = 0;
    q.delete(); n_acc = 0; seen_h = 0; seen_f = 0;
    mon_en = 1;
    // Idle: nothing may be presented and the pc must not move.
    repeat (3) @(negedge clk);
    chk("idle_rom_addr", rom_addr, RESET_PC);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1;
    q.push_back(outcome(1'b0, 32'h0, RESET_PC));
  endtask

  function automatic logic [31:0] pick_target(input int bad_pct);
    logic [31:0] t;
    t = RESET_PC + 32'(4 * $urandom_range(0, ROM_WORDS - 1));
    if ($urandom_range(0, 99) < bad_pct) begin
      case ($urandom_range(0, 2))
        0:       t = t + 32'($urandom_range(1, 3));
        1:       t = RESET_PC + 32'(4 * ROM_WORDS);
        default: t = RESET_PC - 32'd4;
      endcase
    end
    return t;
  endfunction

  // Driver; force_t is used whenever the accepted instruction sits at force_pc.
  task automatic run(input int n, input int rdy_pct, input int br_pct, input int bad_pct,
                     input logic [31:0] force_pc, input logic [31:0] force_t);
    bit          br, acc;
    logic [31:0] t;
    repeat (n) begin
      @(negedge clk);
      instr_ready = ($urandom_range(0, 99) < rdy_pct);
      start = 1'($urandom_range(0, 1));
      acc = instr_valid && instr_ready && (q.size() > 0);
      br = 0; t = $urandom;
      if (acc) begin
        if (q[0].pc == force_pc) begin br = 1; t = force_t; end
        else if ($urandom_range(0, 99) < br_pct) begin br = 1; t = pick_target(bad_pct); end
        q.push_back(outcome(br, t, q[0].pc + 32'd4));
        branch_taken = br;
      end else begin
        branch_taken = ($urandom_range(0, 3) == 0);   // must be ignored
      end
      branch_target = t;
    end
    start = 0; branch_taken = 0;
  endtask

  localparam logic [31:0] NOF = 32'hFFFF_FFF0;  // no forced branch

  initial begin
    // Straight line off the end of the window -> fault at 0x80.
    fill_rom(-1);
    do_reset(); do_start();
    run(300, 70, 0, 0, NOF, 0);
    chk("runoff_fault_seen", 32'(seen_f), 1);

    // Full-rate straight line into a halt at word 22.
    fill_rom(22);
    do_reset(); do_start();
    run(60, 100, 0, 0, NOF, 0);
    chk("halt_seen", 32'(seen_h), 1);
    chk("halt_fetch_count", 32'(fetch_count), 22);
    chk("halt_rom_addr_final", rom_addr, 32'h58);

    // Random legal branches and backpressure, then reset mid-run.
    fill_rom(22);
    do_reset(); do_start();
    run(400, 60, 25, 0, NOF, 0);

    // Random branches including illegal targets.
    fill_rom(-1);
    do_reset(); do_start();
    run(400, 70, 30, 40, NOF, 0);
    chk("bad_branch_fault_seen", 32'(seen_f), 1);

    // Directed redirects from 0x48: legal 0x38, misaligned 0x3A, past window 0x80.
    fill_rom(-1);
    do_reset(); do_start();
    run(80, 100, 0, 0, 32'h48, 32'h38);
    chk("legal_branch_no_fault", 32'(fault), 0);
    do_reset(); do_start();
    run(60, 100, 0, 0, 32'h48, 32'h3A);
    chk("misaligned_fault_seen", 32'(seen_f), 1);
    do_reset(); do_start();
    run(60, 80, 0, 0, 32'h48, 32'h80);
    chk("outside_fault_seen", 32'(seen_f), 1);

    do_reset();
    mon_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
